// File: rtl/instr_register_pkg.sv
// instr_register_pkg
//   Shared types for the instruction register and its executor: slot count,
//   index/operand/opcode/instruction types, the 64-bit signed result type and
//   the executor FSM state encoding.
package instr_register_pkg;

  localparam int DEPTH = 32;
  localparam int IDX_W = $clog2(DEPTH);

  typedef logic [IDX_W-1:0]   index_t;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } exec_state_t;

  // Sign-extend a 32-bit operand so every operation is done at 64 bits.
  function automatic result_t sext_operand(input operand_t v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/instr_alu.sv
// instr_alu
//   Purely combinational execution unit. Operands are sign-extended to 64 bits
//   before the operation, so MULT yields the full product and
//   DIV(-2^31, -1) yields +2^31 without overflow.
// Ports:
//   instruction : captured instruction (opcode + two signed 32-bit operands)
//   result      : signed 64-bit result
//   div_zero    : 1 when the opcode is DIV/MOD and operand b is zero
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t instruction,
  output result_t      result,
  output logic         div_zero
);

  result_t a_s;
  result_t b_s;
  logic    b_zero_s;

  // Opcode decode and arithmetic; divide/mod by zero is forced to 0 so no X escapes.
  always_comb begin
    a_s      = sext_operand(instruction.op_a);
    b_s      = sext_operand(instruction.op_b);
    b_zero_s = (instruction.op_b == 32'sd0);
    result   = 64'sd0;
    div_zero = 1'b0;
    case (instruction.opc)
      ZERO:  result = 64'sd0;
      PASSA: result = a_s;
      PASSB: result = b_s;
      ADD:   result = a_s + b_s;
      SUB:   result = a_s - b_s;
      MULT:  result = a_s * b_s;
      DIV: begin
        if (b_zero_s) begin
          result   = 64'sd0;
          div_zero = 1'b1;
        end else begin
          result   = a_s / b_s;
          div_zero = 1'b0;
        end
      end
      MOD: begin
        if (b_zero_s) begin
          result   = 64'sd0;
          div_zero = 1'b1;
        end else begin
          result   = a_s % b_s;
          div_zero = 1'b0;
        end
      end
      default: begin
        result   = 64'sd0;
        div_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_executor.sv
// instr_executor
//   Reader side of the instruction register. Walks num_instr slots starting
//   at start_index (wrapping modulo DEPTH), captures each instruction,
//   executes it and offers the result on a valid/ready handshake.
//   Per instruction: FETCH (capture) -> EXEC (compute) -> OUT (hold until ready).
// Optional feature (macro INSTR_EXEC_DIVZERO_FLAG_EN): adds div_zero, registered
//   with result, and a sticky div_zero_seen cleared by reset or accepted start.
// Ports:
//   clk, reset_en           : clock, synchronous active-high reset
//   start, start_index,
//   num_instr               : batch request (accepted only in IDLE)
//   read_index, instruction : registered address out, combinational data in
//   result, result_opc,
//   result_valid, result_ready : result handshake
//   busy, done              : not-IDLE indicator, one-cycle end-of-batch pulse
module instr_executor
  import instr_register_pkg::*;
#(
  parameter int DEPTH = instr_register_pkg::DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_en,
  input  logic             start,
  input  index_t           start_index,
  input  logic [CNT_W-1:0] num_instr,
  output index_t           read_index,
  input  instruction_t     instruction,
  output result_t          result,
  output opcode_t          result_opc,
  output logic             result_valid,
  input  logic             result_ready,
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
  output logic             div_zero,
  output logic             div_zero_seen,
`endif
  output logic             busy,
  output logic             done
);

  exec_state_t      state_r;
  exec_state_t      next_state_s;
  index_t           read_index_r;
  logic [CNT_W-1:0] count_r;
  instruction_t     instr_r;
  result_t          result_r;
  opcode_t          result_opc_r;
  logic             result_valid_r;
  logic             busy_r;
  logic             done_r;
  result_t          alu_result_s;
  logic             alu_div_zero_s;
  result_t          result_next_s;
  logic             start_accept_s;
  logic             handshake_s;
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
  logic             div_zero_r;
  logic             div_zero_seen_r;
`endif

  instr_alu u_alu (
    .instruction (instr_r),
    .result      (alu_result_s),
    .div_zero    (alu_div_zero_s)
  );

  // Next-state decode plus handshake/start qualifiers.
  always_comb begin
    next_state_s   = state_r;
    start_accept_s = 1'b0;
    handshake_s    = 1'b0;
    // Redundant guard: a flagged divide never reaches the result register as anything but 0.
    if (alu_div_zero_s) begin
      result_next_s = 64'sd0;
    end else begin
      result_next_s = alu_result_s;
    end
    case (state_r)
      IDLE: begin
        if (start) begin
          start_accept_s = 1'b1;
          if (num_instr == {CNT_W{1'b0}}) begin
            next_state_s = DONE;
          end else begin
            next_state_s = FETCH;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH: next_state_s = EXEC;
      EXEC:  next_state_s = OUT;
      OUT: begin
        if (result_ready) begin
          handshake_s = 1'b1;
          if (count_r == CNT_W'(1'b1)) begin
            next_state_s = DONE;
          end else begin
            next_state_s = FETCH;
          end
        end else begin
          next_state_s = OUT;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset_en) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath: index/count sequencing, instruction capture, result hold, status flags.
  always_ff @(posedge clk) begin
    if (reset_en) begin
      read_index_r   <= '0;
      count_r        <= {CNT_W{1'b0}};
      instr_r        <= '{opc: ZERO, default: '0};
      result_r       <= 64'sd0;
      result_opc_r   <= ZERO;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
      div_zero_r      <= 1'b0;
      div_zero_seen_r <= 1'b0;
`endif
    end else begin
      busy_r <= (next_state_s != IDLE);
      done_r <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start_accept_s && (num_instr != {CNT_W{1'b0}})) begin
            read_index_r <= start_index;
            count_r      <= num_instr;
          end
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
          if (start_accept_s) begin
            div_zero_seen_r <= 1'b0;
          end
`endif
        end
        FETCH: instr_r <= instruction;
        EXEC: begin
          result_r       <= result_next_s;
          result_opc_r   <= instr_r.opc;
          result_valid_r <= 1'b1;
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
          div_zero_r <= alu_div_zero_s;
          if (alu_div_zero_s) begin
            div_zero_seen_r <= 1'b1;
          end
`endif
        end
        OUT: begin
          if (handshake_s) begin
            result_valid_r <= 1'b0;
            count_r        <= count_r - CNT_W'(1'b1);
            if (read_index_r == index_t'(DEPTH - 1)) begin
              read_index_r <= '0;
            end else begin
              read_index_r <= read_index_r + 1'b1;
            end
          end
        end
        DONE: begin
          result_valid_r <= 1'b0;
        end
        default: begin
          result_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign read_index   = read_index_r;
  assign result       = result_r;
  assign result_opc   = result_opc_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
  assign div_zero      = div_zero_r;
  assign div_zero_seen = div_zero_seen_r;
`endif

endmodule

// File: doc/instr_executor.md
Name: instr_executor

Overview:
- Consumer/reader side of the instruction register.
- Sequentially drives `read_index`, captures the combinationally-read `instruction_t`, executes the opcode, and presents a 64-bit signed result on a valid/ready output handshake.
- Sits between the instruction register and the result checker / downstream scoreboard.
- Runs a batch of `num_instr` instructions starting at `start_index`, wrapping modulo `DEPTH`.

Parameters:
- DEPTH, default from `instr_register_pkg` (32), number of instruction slots. Sets the index wrap point.
- CNT_W, default `$clog2(DEPTH)+1`, width of the batch count (allows 0..DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- reset_en  input  1  synchronous, active-high reset (1 = reset, sampled on posedge `clk`).
- start  input  1  batch request; accepted only in IDLE.
- start_index  input  index_t  first slot to execute.
- num_instr  input  CNT_W  number of instructions in the batch.
- read_index  output  index_t  address to instruction register, registered.
- instruction  input  instruction_t  combinational read data for `read_index`.
- result  output  result_t  signed 64-bit execution result.
- result_opc  output  opcode_t  opcode that produced `result`.
- result_valid  output  1  result available.
- result_ready  input  1  downstream accepts result.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at batch end.

Behaviour:
- Reset (synchronous, whole block; overrides mid-batch operation): state=IDLE, read_index=0, result=0, result_opc=ZERO, result_valid=0, busy=0, done=0, internal count=0, captured instruction='{opc:ZERO, default:0}.
- FSM states: IDLE, FETCH, EXEC, OUT, DONE.
- IDLE:
  - `start`=1 with `num_instr`=0 -> DONE; no result produced.
  - `start`=1 with `num_instr`!=0 -> load read_index=start_index and count=num_instr, go to FETCH.
  - `start` in any other state is ignored.
- FETCH: `instruction` is valid this cycle because read is combinational and `read_index` is already stable. Register it, go to EXEC.
- EXEC: compute result from the captured instruction into the `result`/`result_opc` registers, assert result_valid, go to OUT.
- OUT: hold `result`, `result_opc` and `result_valid`=1 stable until `result_ready`=1 (AXI-style; `result_valid` never drops without a handshake).
- On handshake in OUT:
  - result_valid->0, count-1, read_index+1 (wraps DEPTH-1 -> 0).
  - count reaching 0 -> DONE; else -> FETCH.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - start -> first result_valid = 3 cycles.
  - Per-instruction throughput = 3 cycles + ready stall.
- Arithmetic: operands are signed 32-bit, sign-extended to 64 bits before the operation.
  - ZERO -> 0
  - PASSA -> a
  - PASSB -> b
  - ADD -> a+b
  - SUB -> a-b
  - MULT -> full 64-bit product
  - DIV -> truncates toward zero
  - MOD -> remainder carries the sign of the dividend
  - Divide/mod by zero -> 0, no X propagation.
  - DIV of -2^31 by -1 -> +2^31; no overflow, because the operation is computed at 64 bits.
- The instruction register may be rewritten while a batch runs. The block uses whatever is present at the FETCH cycle.

Optional Feature:
- Macro INSTR_EXEC_DIVZERO_FLAG_EN.
- When defined:
  - Adds output port `div_zero`, 1 bit. It is registered alongside `result` and is 1 when the held result came from DIV/MOD with b=0; 0 otherwise and after reset.
  - Adds a sticky `div_zero_seen` output, cleared by reset or by an accepted `start`.
- When undefined: neither port exists; divide-by-zero silently yields 0.

Decomposition:
- `instr_register_pkg` gains:
  - `result_t` (logic signed [63:0])
  - an FSM state enum `exec_state_t`
- It continues to supply `DEPTH`, `index_t`, `operand_t`, `opcode_t` and `instruction_t`.
- One natural sub-module: `instr_alu`, purely combinational. Inputs are `instruction_t`; outputs are `result_t` and the div-zero indication. The FSM and handshake stay in `instr_executor`.

Test Plan:
- Reset mid-batch: assert `reset_en` in OUT with result_valid=1 -> next cycle result_valid=0, busy=0, read_index=0; the subsequent `start` runs normally.
- Batch: load slots 0..3 with ADD(5,7), SUB(3,10), MULT(-4,6), DIV(-7,2); start_index=0, num_instr=4, result_ready tied 1 -> results 12, -7, -24, -3 in order, each 3 cycles apart; done pulse after the 4th.
- Wrap: start_index=30, num_instr=4 -> read_index sequence 30, 31, 0, 1.
- Backpressure: hold result_ready=0 for 5 cycles in OUT -> result, result_opc and result_valid stay constant; read_index does not advance.
- Edge arithmetic:
  - MOD(-7,2) -> -1
  - DIV(-2147483648,-1) -> 2147483648
  - MULT(2147483647,2147483647) -> 4611686014132420609
  - DIV(9,0) -> 0, with div_zero=1 when the macro is defined.
- Zero-length and ignored start: num_instr=0 -> done 1 cycle after start, no result_valid; a `start` pulse during busy is ignored.
